md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
// - Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline; owns the HI/LO registers.
// - Executes mult/multu/div/divu with fixed multi-cycle latency, plus mthi/mtlo writes.
// - hi/lo feed the EX result-select mux_4_32 that resolves mfhi/mflo.
// - busy feeds the hazard unit, which stalls ID while a later MD instruction waits.
// PARAMETERS
// - MULT_CYCLES  5   busy cycles for mult/multu (>=1)
// - DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
// - clk     in   1   clock; all state updates on rising edge
// - reset   in   1   synchronous, active-high reset
// - md_op   in   3   000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
// - a       in   32  rs operand (already forwarded)
// - b       in   32  rt operand (already forwarded)
// - busy    out  1   registered; 1 while an operation is in flight
// - hi      out  32  HI register contents
// - lo      out  32  LO register contents
// BEHAVIOUR
// - Clock and reset: one clock (clk); reset is synchronous and active-high.
// - Reset: busy=0, hi=0, lo=0, cycle counter=0, pending results=0.
// - Reset mid-operation: aborts the operation; nothing is written to HI/LO.
// - States:
//   - IDLE (busy=0)
//   - RUN (busy=1); down-counter cnt holds the remaining cycles.
// - Issue in IDLE, cycle T, md_op in {mult,multu,div,divu}:
//   - Full 64-bit result latched into internal pend_hi/pend_lo at the edge ending T.
//   - cnt loaded with N-1 (N = MULT_CYCLES or DIV_CYCLES); state goes to RUN.
//   - busy=1 during cycles T+1..T+N.
// - RUN: cnt decrements each cycle.
//   - At the edge ending cycle T+N (cnt==0): hi<=pend_hi, lo<=pend_lo, state goes to IDLE.
//   - New values are visible, and busy=0, from cycle T+N+1.
// - hi/lo never change during RUN; they keep their old values until completion.
// - Arithmetic:
//   - mult:  {hi,lo} = signed(a)*signed(b), 64-bit.
//   - multu: {hi,lo} = unsigned(a)*unsigned(b), 64-bit.
//   - div:   lo = quotient truncated toward zero; hi = remainder with the sign of a.
//   - div with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
//   - divu:  lo = a/b, hi = a%b, unsigned.
//   - b==0 on div/divu: busy timing unchanged; HI/LO left unmodified at completion.
// - mthi/mtlo in IDLE: hi<=a or lo<=a at the edge ending the issue cycle; busy stays 0.
// - Any nonzero md_op while busy=1 is ignored.
//   - The hazard unit guarantees none is issued; the block still must not corrupt state.
// - md_op=000/111: no effect.
// - Op issued in the first cycle after completion (T+N+1) starts normally.
// - mfhi/mflo are not ops here; the pipeline reads hi/lo directly.
// TESTING
// - mult a=0xFFFFFFFE(-2), b=3:
//   - busy=1 for exactly 5 cycles.
//   - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
// - multu a=0xFFFFFFFF, b=0xFFFFFFFF:
//   - Then hi=0xFFFFFFFE, lo=0x00000001.
// - div a=-7 (0xFFFFFFF9), b=2:
//   - busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
// - divu a=7, b=0 after mthi 0x1234 and mtlo 0x5678:
//   - busy for 10 cycles; hi=0x1234, lo=0x5678 unchanged.
// - mult issued, then mtlo 0xAAAA presented in the 2nd busy cycle:
//   - mtlo ignored; final lo = product low word.
// - reset asserted in the 3rd busy cycle of a div:
//   - next cycle busy=0, hi=0, lo=0; no later write.

Source files
------------

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multiply/divide unit owning HI/LO, fixed-latency mult/div plus mthi/mtlo
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   pend_hi, pend_hi_nxt, pend_lo, pend_lo_nxt;
    logic          pend_wr, pend_wr_nxt;
    logic [31:0]   hi_nxt, lo_nxt;

    // Sign-extending both operands to 64 bits makes the low 64 bits of an
    // unsigned multiply equal to the signed product.
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'b0, a} * {32'b0, b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 cannot overflow.
    logic        sgn;
    logic [31:0] a_mag, b_mag, dn, dd, q, r, quo_s, rem_s;
    assign sgn   = (md_op == OP_DIV);
    assign a_mag = a[31] ? (32'd0 - a) : a;
    assign b_mag = b[31] ? (32'd0 - b) : b;
    assign dn    = sgn ? a_mag : a;
    assign dd    = sgn ? b_mag : b;
    assign q     = dn / ((dd == 32'd0) ? 32'd1 : dd);
    assign r     = dn % ((dd == 32'd0) ? 32'd1 : dd);
    assign quo_s = (a[31] ^ b[31]) ? (32'd0 - q) : q;
    assign rem_s = a[31] ? (32'd0 - r) : r;

    assign busy = (state == RUN);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_wr_nxt = pend_wr;
        hi_nxt      = hi;
        lo_nxt      = lo;
        case (state)
            IDLE: begin
                case (md_op)
                    OP_MULT, OP_MULTU: begin
                        {pend_hi_nxt, pend_lo_nxt} = (md_op == OP_MULT) ? prod_s : prod_u;
                        pend_wr_nxt = 1'b1;
                        cnt_nxt     = CW'(MULT_CYCLES - 1);
                        state_nxt   = RUN;
                    end
                    OP_DIV, OP_DIVU: begin
                        pend_hi_nxt = sgn ? rem_s : r;
                        pend_lo_nxt = sgn ? quo_s : q;
                        pend_wr_nxt = (b != 32'd0);
                        cnt_nxt     = CW'(DIV_CYCLES - 1);
                        state_nxt   = RUN;
                    end
                    OP_MTHI: hi_nxt = a;
                    OP_MTLO: lo_nxt = a;
                    default: ;
                endcase
            end
            RUN: begin
                if (cnt == '0) begin
                    if (pend_wr) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_wr <= pend_wr_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit against a cycle-level reference model
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  md_op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: counts remaining busy cycles and holds the result to commit.
    int          m_left = 0;
    bit          m_wr   = 1'b0;
    logic [31:0] m_ph = '0, m_pl = '0, m_hi = '0, m_lo = '0;

    always @(posedge clk) begin
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        if (reset) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_wr = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_wr) begin
                m_hi = m_ph; m_lo = m_pl;
            end
        end else begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
            case (md_op)
                3'd1: begin p = 64'(sa * sb); {m_ph, m_pl} = p; m_wr = 1'b1; m_left = 5; end
                3'd2: begin p = 64'(ua * ub); {m_ph, m_pl} = p; m_wr = 1'b1; m_left = 5; end
                3'd3: begin
                    m_wr = (b != 0); m_left = 10;
                    if (m_wr) begin m_pl = 32'(sa / sb); m_ph = 32'(sa % sb); end
                end
                3'd4: begin
                    m_wr = (b != 0); m_left = 10;
                    if (m_wr) begin m_pl = 32'(ua / ub); m_ph = 32'(ua % ub); end
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    // Issue at the current negedge, then count busy cycles until IDLE.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input int exp_n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        md_op = op; a = av; b = bv;
        @(negedge clk);
        md_op = 3'd0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, "_cycles"}, 32'(n), 32'(exp_n));
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        reset = 1'b1; md_op = 3'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        chk_en = 1'b1;
        reset = 1'b0;

        run_op("mult_neg", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_mix", 3'd1, 32'd7, 32'hFFFFFFFB, 5, 32'hFFFFFFFF, 32'hFFFFFFDD);
        run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        run_op("divu", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("mthi", 3'd5, 32'h1234, 32'd0, 0, 32'h1234, 32'd14);
        run_op("mtlo", 3'd6, 32'h5678, 32'd0, 0, 32'h1234, 32'h5678);
        run_op("divu_zero", 3'd4, 32'd7, 32'd0, 10, 32'h1234, 32'h5678);
        run_op("div_zero", 3'd3, 32'hFFFFFFF9, 32'd0, 10, 32'h1234, 32'h5678);
        run_op("op7_none", 3'd7, 32'hDEAD, 32'hBEEF, 0, 32'h1234, 32'h5678);

        // mtlo in the second busy cycle must be ignored
        md_op = 3'd1; a = 32'h00010001; b = 32'h00010001;
        @(negedge clk);
        md_op = 3'd0;
        @(negedge clk);
        md_op = 3'd6; a = 32'hAAAA;
        @(negedge clk);
        md_op = 3'd0;
        repeat (5) @(negedge clk);
        check("mtlo_busy_hi", hi, 32'h00000001);
        check("mtlo_busy_lo", lo, 32'h00020001);

        // reset in the third busy cycle of a div aborts it
        md_op = 3'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        md_op = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);

        run_op("post_abort", 3'd2, 32'd6, 32'd7, 5, 32'd0, 32'd42);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
